// File: rtl/bsg_link_pkg.sv
// Shared definitions for the BSG-style serial link: default widths, beat count,
// channel state encoding and beat-index sizing.
package bsg_link_pkg;

    localparam int CORE_W_DEF = 32;
    localparam int IO_W_DEF   = 8;
    localparam int BEATS_DEF  = CORE_W_DEF / IO_W_DEF;

    // A single-beat link still needs a one-bit index so the counter has a legal width.
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEAT_IDX_W_DEF = beat_idx_w(BEATS_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } link_state_e;

endpackage

// File: rtl/bsg_credit_counter.sv
// Credit pool for a token-flow-controlled link: spends one credit per launch,
// recovers one per returned token, saturates at CREDITS and flags overflow.
module bsg_credit_counter #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic full;
    logic empty;

    assign full  = (cnt == CNT_W'(CREDITS));
    assign empty = (cnt == '0);

    // A simultaneous token and launch cancel; a token into a full pool is a protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(CREDITS);
            ovf <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/bsg_upstream_ch.sv
// Upstream link channel: serialises CORE_W words into IO_W beats, LS slice first,
// gated by downstream credits, with zero-bubble back-to-back word acceptance.
module bsg_upstream_ch
    import bsg_link_pkg::*;
#(
    parameter int CORE_W  = CORE_W_DEF,
    parameter int IO_W    = IO_W_DEF,
    parameter int CREDITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             core_valid_in,
    input  logic [CORE_W-1:0]                core_data_in,
    output logic                             core_ready_out,
    output logic                             io_valid_out,
    output logic [IO_W-1:0]                  io_data_out,
    input  logic                             io_token_in,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
    output logic                             credit_ovf
);

    localparam int BEATS = CORE_W / IO_W;
    localparam int IDX_W = beat_idx_w(BEATS);
    localparam int CNT_W = $clog2(CREDITS + 1);

    link_state_e                 state_q;
    link_state_e                 state_d;
    logic [IDX_W-1:0]            idx_q;
    logic [BEATS-1:0][IO_W-1:0]  word_q;
    logic                        launch;
    logic                        last_beat;
    logic                        handshake;

    // Ready opens in SEND only on the cycle the final beat goes out, so the next word
    // can be loaded without an idle cycle in between.
    always_comb begin
        state_d        = state_q;
        launch         = 1'b0;
        last_beat      = 1'b0;
        core_ready_out = 1'b0;
        handshake      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                core_ready_out = 1'b1;
                handshake      = core_valid_in;
                if (handshake) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                launch         = (credit_cnt != '0);
                last_beat      = launch && (idx_q == IDX_W'(BEATS - 1));
                core_ready_out = last_beat;
                handshake      = core_valid_in && last_beat;
                if (last_beat && !handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (handshake) begin
            word_q <= core_data_in;
            idx_q  <= '0;
        end else if (launch) begin
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // Link outputs are registered; the payload holds its last beat while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_valid_out <= 1'b0;
            io_data_out  <= '0;
        end else begin
            io_valid_out <= launch;
            if (launch) begin
                io_data_out <= word_q[idx_q];
            end
        end
    end

    bsg_credit_counter #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (io_token_in),
        .dec   (launch),
        .cnt   (credit_cnt),
        .ovf   (credit_ovf)
    );

endmodule

// File: tb/tb_bsg_upstream_ch.sv
// Directed bench for bsg_upstream_ch: expected beats are queued when words are offered
// and checked by a negedge monitor; credit, ready and reset behaviour are checked inline.
module tb_bsg_upstream_ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_valid_in;
    logic [31:0] core_data_in;
    logic        core_ready_out;
    logic        io_valid_out;
    logic [7:0]  io_data_out;
    logic        io_token_in;
    logic [2:0]  credit_cnt;
    logic        credit_ovf;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    bsg_upstream_ch #(
        .CORE_W  (32),
        .IO_W    (8),
        .CREDITS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_valid_in  (core_valid_in),
        .core_data_in   (core_data_in),
        .core_ready_out (core_ready_out),
        .io_valid_out   (io_valid_out),
        .io_data_out    (io_data_out),
        .io_token_in    (io_token_in),
        .credit_cnt     (credit_cnt),
        .credit_ovf     (credit_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic token);
        core_valid_in = valid;
        core_data_in  = data;
        io_token_in   = token;
    endtask

    task automatic pushWord(input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(word[i*8 +: 8]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every visible beat must match the oldest outstanding expected beat.
    always @(negedge clk) begin
        if (rst_n && io_valid_out) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_beat: observed 0x%0h, expected no beat", io_data_out);
            end
            if (exp_q.size() != 0) begin
                checkOutput("beat_data", 32'(io_data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int credit_exp[6];
        int ready_exp[6];
        int valid_exp[6];
        credit_exp = '{4, 3, 2, 1, 0, 0};
        ready_exp  = '{0, 0, 0, 1, 1, 1};
        valid_exp  = '{0, 1, 1, 1, 1, 0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_io_valid", 32'(io_valid_out), 32'd0);
        checkOutput("rst_io_data", 32'(io_data_out), 32'd0);
        checkOutput("rst_credit", 32'(credit_cnt), 32'd4);
        checkOutput("rst_ovf", 32'(credit_ovf), 32'd0);
        rst_n = 1'b1;

        // Single word with full credits: beats in cycles 2..5, credits drain to 0.
        checkOutput("ready_after_reset", 32'(core_ready_out), 32'd1);
        applyStimulus(1'b1, 32'hA1B2C3D4, 1'b0);
        pushWord(32'hA1B2C3D4);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);
            checkOutput($sformatf("w0_credit_c%0d", k), 32'(credit_cnt), 32'(credit_exp[k-1]));
            checkOutput($sformatf("w0_ready_c%0d", k), 32'(core_ready_out), 32'(ready_exp[k-1]));
            checkOutput($sformatf("w0_valid_c%0d", k), 32'(io_valid_out), 32'(valid_exp[k-1]));
        end
        checkOutput("w0_data_hold", 32'(io_data_out), 32'hA1);

        // Zero credits: word waits in SEND; a single token releases exactly one beat.
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
        pushWord(32'hCAFEF00D);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("stall_ready", 32'(core_ready_out), 32'd0);
        checkOutput("stall_credit", 32'(credit_cnt), 32'd0);
        tick();
        checkOutput("stall_valid", 32'(io_valid_out), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("token_credit", 32'(credit_cnt), 32'd1);
        checkOutput("token_ready", 32'(core_ready_out), 32'd0);
        tick();
        checkOutput("one_beat_valid", 32'(io_valid_out), 32'd1);
        checkOutput("one_beat_credit", 32'(credit_cnt), 32'd0);
        tick();
        checkOutput("one_beat_only", 32'(io_valid_out), 32'd0);
        checkOutput("one_beat_credit_back", 32'(credit_cnt), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (7) tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("refill_credit", 32'(credit_cnt), 32'd4);
        checkOutput("refill_ready", 32'(core_ready_out), 32'd1);
        checkOutput("refill_valid", 32'(io_valid_out), 32'd0);

        // Back-to-back words with a token every cycle: eight contiguous beats.
        applyStimulus(1'b1, 32'h11223344, 1'b0);
        checkOutput("b2b_ready_w1", 32'(core_ready_out), 32'd1);
        pushWord(32'h11223344);
        for (int k = 1; k <= 9; k++) begin
            tick();
            applyStimulus(k <= 4, 32'h55667788, k <= 8);
            if (k == 4) pushWord(32'h55667788);
            checkOutput($sformatf("b2b_ready_c%0d", k), 32'(core_ready_out),
                        32'((k == 4) || (k == 8) || (k == 9)));
            checkOutput($sformatf("b2b_valid_c%0d", k), 32'(io_valid_out), 32'(k >= 2));
            checkOutput($sformatf("b2b_credit_c%0d", k), 32'(credit_cnt), 32'd4);
        end
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("b2b_end_valid", 32'(io_valid_out), 32'd0);
        checkOutput("b2b_ovf", 32'(credit_ovf), 32'd0);

        // Token and launch in the same cycle at two credits.
        applyStimulus(1'b1, 32'h0BADBEEF, 1'b0);
        pushWord(32'h0BADBEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("same_cyc_c1", 32'(credit_cnt), 32'd4);
        tick();
        checkOutput("same_cyc_c2", 32'(credit_cnt), 32'd3);
        tick();
        checkOutput("same_cyc_c3", 32'(credit_cnt), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("same_cyc_hold", 32'(credit_cnt), 32'd2);
        tick();
        checkOutput("same_cyc_after", 32'(credit_cnt), 32'd1);
        checkOutput("same_cyc_idle", 32'(core_ready_out), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("same_cyc_refill", 32'(credit_cnt), 32'd4);
        checkOutput("same_cyc_ovf", 32'(credit_ovf), 32'd0);

        // Token into a full pool: saturate and raise the sticky overflow flag.
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("ovf_credit", 32'(credit_cnt), 32'd4);
        checkOutput("ovf_set", 32'(credit_ovf), 32'd1);
        repeat (2) tick();
        checkOutput("ovf_sticky", 32'(credit_ovf), 32'd1);

        // Reset after beat 1 of a word: remaining beats are discarded.
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(io_valid_out), 32'd0);
        checkOutput("midrst_data", 32'(io_data_out), 32'd0);
        checkOutput("midrst_credit", 32'(credit_cnt), 32'd4);
        checkOutput("midrst_ovf", 32'(credit_ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_ready", 32'(core_ready_out), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput($sformatf("post_rst_valid_c%0d", k), 32'(io_valid_out), 32'd0);
            checkOutput($sformatf("post_rst_credit_c%0d", k), 32'(credit_cnt), 32'd4);
        end
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
